// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register carrying a control field and a data field between
// two valid/ready handshakes.
//
// SKID = 1 : two-entry skid buffer. ready_o comes from registered state only,
//            so there is no combinational path from ready_i back upstream.
// SKID = 0 : single register. ready_o = !valid_o | ready_i (combinational).
//
// Parameters
//   CTRL_W  width of the control field (WB/MEM/EX bits), 1..64
//   DATA_W  width of the data field (addresses, operands, immediates), 1..512
//   SKID    1 = two-entry skid buffer, 0 = single register
//
// Ports
//   clk_i    clock, all state updates on the rising edge
//   rst_i    synchronous active-high reset, highest priority
//   flush_i  synchronous discard of all held entries (below reset)
//   valid_i  upstream entry is valid
//   ready_o  stage can accept an entry this cycle
//   ctrl_i   upstream control field
//   data_i   upstream data field
//   valid_o  downstream entry is valid
//   ready_i  downstream accepts this cycle
//   ctrl_o   registered control field, all zeros whenever valid_o = 0
//   data_o   registered data field, holds its last value in a bubble
//   count_o  number of held entries (0..2, or 0..1 when SKID = 0)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned DATA_W = 138,
   parameter int unsigned SKID   = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        count_o
);

   // Elaboration-time range checks on the parameters.
   if (CTRL_W < 1 || CTRL_W > 64) begin : g_bad_ctrl_w
      $error("pipe_stage_reg: CTRL_W must be in 1..64");
   end
   if (DATA_W < 1 || DATA_W > 512) begin : g_bad_data_w
      $error("pipe_stage_reg: DATA_W must be in 1..512");
   end
   if (SKID > 1) begin : g_bad_skid
      $error("pipe_stage_reg: SKID must be 0 or 1");
   end

   // Handshake events, both evaluated in the same cycle.
   logic accept;
   logic issue;

   assign accept = valid_i & ready_o;
   assign issue  = valid_o & ready_i;

   if (SKID != 0) begin : g_skid
      // ----------------------------------------------------------------------
      // Two-entry skid buffer. "main" drives the outputs; "skid" catches the
      // entry accepted while main is stalled. The encoding equals occupancy.
      // ----------------------------------------------------------------------
      typedef enum logic [1:0] {
         StEmpty = 2'd0,
         StOne   = 2'd1,
         StTwo   = 2'd2
      } state_e;

      state_e            state_q, state_d;
      logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
      logic [DATA_W-1:0] main_data_q, main_data_d;
      logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
      logic [DATA_W-1:0] skid_data_q, skid_data_d;

      always_comb begin
         state_d     = state_q;
         main_ctrl_d = main_ctrl_q;
         main_data_d = main_data_q;
         skid_ctrl_d = skid_ctrl_q;
         skid_data_d = skid_data_q;

         if (flush_i) begin
            // Offered entry is dropped; an issue this cycle is still consumed
            // downstream, so nothing is retained. Data keeps its last value.
            state_d     = StEmpty;
            main_ctrl_d = '0;
         end else begin
            case (state_q)
               StEmpty: begin
                  if (accept) begin
                     state_d     = StOne;
                     main_ctrl_d = ctrl_i;
                     main_data_d = data_i;
                  end
               end
               StOne: begin
                  if (accept && issue) begin
                     main_ctrl_d = ctrl_i;
                     main_data_d = data_i;
                  end else if (accept) begin
                     state_d     = StTwo;
                     skid_ctrl_d = ctrl_i;
                     skid_data_d = data_i;
                  end else if (issue) begin
                     // Bubble: control cleared so no write enables leak out.
                     state_d     = StEmpty;
                     main_ctrl_d = '0;
                  end
               end
               StTwo: begin
                  // ready_o is low here, so accept cannot occur.
                  if (issue) begin
                     state_d     = StOne;
                     main_ctrl_d = skid_ctrl_q;
                     main_data_d = skid_data_q;
                  end
               end
               default: begin
                  state_d     = StEmpty;
                  main_ctrl_d = '0;
               end
            endcase
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
         end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
         end
      end

      assign ready_o = (state_q != StTwo);
      assign valid_o = (state_q != StEmpty);
      assign ctrl_o  = main_ctrl_q;
      assign data_o  = main_data_q;
      assign count_o = state_q;

   end else begin : g_single
      // ----------------------------------------------------------------------
      // Single register. Upstream may load whenever the slot is empty or is
      // being drained in the same cycle.
      // ----------------------------------------------------------------------
      logic              valid_q, valid_d;
      logic [CTRL_W-1:0] ctrl_q, ctrl_d;
      logic [DATA_W-1:0] data_q, data_d;

      always_comb begin
         valid_d = valid_q;
         ctrl_d  = ctrl_q;
         data_d  = data_q;

         if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
         end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
         end else if (issue) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
         end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
         end
      end

      assign ready_o = ~valid_q | ready_i;
      assign valid_o = valid_q;
      assign ctrl_o  = ctrl_q;
      assign data_o  = data_q;
      assign count_o = {1'b0, valid_q};
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         flush;

   // Skid-buffer instance (SKID = 1)
   logic         valid_in;
   logic         ready_in;
   logic [7:0]   ctrl_in;
   logic [137:0] data_in;
   logic         ready_out;
   logic         valid_out;
   logic [7:0]   ctrl_out;
   logic [137:0] data_out;
   logic [1:0]   count_out;

   // Single-register instance (SKID = 0)
   logic         s_valid_in;
   logic         s_ready_in;
   logic [7:0]   s_ctrl_in;
   logic [137:0] s_data_in;
   logic         s_ready_out;
   logic         s_valid_out;
   logic [7:0]   s_ctrl_out;
   logic [137:0] s_data_out;
   logic [1:0]   s_count_out;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_stage_reg #(.CTRL_W(8), .DATA_W(138), .SKID(1)) u_skid (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .valid_i (valid_in),
      .ready_o (ready_out),
      .ctrl_i  (ctrl_in),
      .data_i  (data_in),
      .valid_o (valid_out),
      .ready_i (ready_in),
      .ctrl_o  (ctrl_out),
      .data_o  (data_out),
      .count_o (count_out)
   );

   pipe_stage_reg #(.CTRL_W(8), .DATA_W(138), .SKID(0)) u_single (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .valid_i (s_valid_in),
      .ready_o (s_ready_out),
      .ctrl_i  (s_ctrl_in),
      .data_i  (s_data_in),
      .valid_o (s_valid_out),
      .ready_i (s_ready_in),
      .ctrl_o  (s_ctrl_out),
      .data_o  (s_data_out),
      .count_o (s_count_out)
   );

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; flush = 1'b0;
      valid_in = 1'b1; ready_in = 1'b0; ctrl_in = 8'hFF; data_in = 138'd77;
      s_valid_in = 1'b1; s_ready_in = 1'b0; s_ctrl_in = 8'hFF; s_data_in = 138'd77;
      tick();
      tick();
      n_tests++;
      if (valid_out !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid got %b exp 0", valid_out);
      end
      n_tests++;
      if (ctrl_out !== 8'h00) begin
         n_fail++; $display("FAIL reset_ctrl got %h exp 00", ctrl_out);
      end
      n_tests++;
      if (data_out !== 138'd0) begin
         n_fail++; $display("FAIL reset_data got %0h exp 0", data_out);
      end
      n_tests++;
      if (count_out !== 2'd0) begin
         n_fail++; $display("FAIL reset_count got %0d exp 0", count_out);
      end
      n_tests++;
      if (ready_out !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got %b exp 1", ready_out);
      end
      n_tests++;
      if (s_valid_out !== 1'b0 || s_ctrl_out !== 8'h00 || s_data_out !== 138'd0) begin
         n_fail++;
         $display("FAIL reset_single got v=%b c=%h d=%0h exp 0/00/0",
                  s_valid_out, s_ctrl_out, s_data_out);
      end
      rst = 1'b0;
      valid_in = 1'b0; s_valid_in = 1'b0;
      ctrl_in = 8'h00; s_ctrl_in = 8'h00;
   endtask

   task automatic test_single_accept;
      valid_in = 1'b1; ctrl_in = 8'hA5; data_in = 138'd1; ready_in = 1'b1;
      tick();
      valid_in = 1'b0;
      n_tests++;
      if (valid_out !== 1'b1 || ctrl_out !== 8'hA5 || data_out !== 138'd1) begin
         n_fail++;
         $display("FAIL single_out got v=%b c=%h d=%0h exp 1/a5/1",
                  valid_out, ctrl_out, data_out);
      end
      n_tests++;
      if (count_out !== 2'd1) begin
         n_fail++; $display("FAIL single_count got %0d exp 1", count_out);
      end
      tick();
      n_tests++;
      if (valid_out !== 1'b0 || ctrl_out !== 8'h00) begin
         n_fail++; $display("FAIL single_bubble got v=%b c=%h exp 0/00", valid_out, ctrl_out);
      end
      n_tests++;
      if (data_out !== 138'd1) begin
         n_fail++; $display("FAIL single_data_hold got %0h exp 1", data_out);
      end
      n_tests++;
      if (count_out !== 2'd0) begin
         n_fail++; $display("FAIL single_count_empty got %0d exp 0", count_out);
      end
   endtask

   task automatic test_backpressure;
      ready_in = 1'b0;
      valid_in = 1'b1; ctrl_in = 8'h11; data_in = 138'd1;
      tick();
      n_tests++;
      if (count_out !== 2'd1 || ready_out !== 1'b1 || data_out !== 138'd1) begin
         n_fail++;
         $display("FAIL bp_first got cnt=%0d rdy=%b d=%0h exp 1/1/1",
                  count_out, ready_out, data_out);
      end
      ctrl_in = 8'h22; data_in = 138'd2;
      tick();
      n_tests++;
      if (count_out !== 2'd2 || ready_out !== 1'b0) begin
         n_fail++; $display("FAIL bp_full got cnt=%0d rdy=%b exp 2/0", count_out, ready_out);
      end
      ctrl_in = 8'h33; data_in = 138'd3;
      tick();
      n_tests++;
      if (count_out !== 2'd2 || valid_out !== 1'b1 || ctrl_out !== 8'h11
          || data_out !== 138'd1) begin
         n_fail++;
         $display("FAIL bp_stall got cnt=%0d v=%b c=%h d=%0h exp 2/1/11/1",
                  count_out, valid_out, ctrl_out, data_out);
      end
      // Downstream frees up; ready_o must not follow ready_i combinationally.
      ready_in = 1'b1;
      #1;
      n_tests++;
      if (ready_out !== 1'b0) begin
         n_fail++; $display("FAIL bp_ready_reg got %b exp 0", ready_out);
      end
      tick();
      n_tests++;
      if (data_out !== 138'd2 || ctrl_out !== 8'h22 || count_out !== 2'd1) begin
         n_fail++;
         $display("FAIL bp_drain2 got d=%0h c=%h cnt=%0d exp 2/22/1",
                  data_out, ctrl_out, count_out);
      end
      tick();
      valid_in = 1'b0;
      n_tests++;
      if (data_out !== 138'd3 || ctrl_out !== 8'h33 || count_out !== 2'd1) begin
         n_fail++;
         $display("FAIL bp_drain3 got d=%0h c=%h cnt=%0d exp 3/33/1",
                  data_out, ctrl_out, count_out);
      end
      tick();
      n_tests++;
      if (valid_out !== 1'b0 || count_out !== 2'd0) begin
         n_fail++; $display("FAIL bp_empty got v=%b cnt=%0d exp 0/0", valid_out, count_out);
      end
   endtask

   task automatic test_streaming;
      ready_in = 1'b1; valid_in = 1'b1;
      for (int i = 0; i < 16; i++) begin
         data_in = 138'(i);
         ctrl_in = 8'(i + 1);
         tick();
         n_tests++;
         if (data_out !== 138'(i) || ctrl_out !== 8'(i + 1) || count_out !== 2'd1
             || ready_out !== 1'b1 || valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL stream[%0d] got d=%0h c=%h cnt=%0d rdy=%b v=%b exp %0h/%h/1/1/1",
                     i, data_out, ctrl_out, count_out, ready_out, valid_out, i, i + 1);
         end
      end
      valid_in = 1'b0;
      tick();
      n_tests++;
      if (valid_out !== 1'b0 || count_out !== 2'd0) begin
         n_fail++; $display("FAIL stream_end got v=%b cnt=%0d exp 0/0", valid_out, count_out);
      end
   endtask

   task automatic test_flush;
      ready_in = 1'b0; valid_in = 1'b1;
      ctrl_in = 8'h07; data_in = 138'd7;
      tick();
      ctrl_in = 8'h08; data_in = 138'd8;
      tick();
      n_tests++;
      if (count_out !== 2'd2) begin
         n_fail++; $display("FAIL flush_fill got %0d exp 2", count_out);
      end
      flush = 1'b1; ctrl_in = 8'h09; data_in = 138'd9;
      tick();
      flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
      n_tests++;
      if (valid_out !== 1'b0 || ctrl_out !== 8'h00 || count_out !== 2'd0
          || ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_state got v=%b c=%h cnt=%0d rdy=%b exp 0/00/0/1",
                  valid_out, ctrl_out, count_out, ready_out);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (valid_out !== 1'b0 || data_out === 138'd9) begin
            n_fail++;
            $display("FAIL flush_no9[%0d] got v=%b d=%0h exp v=0 d!=9", i, valid_out, data_out);
         end
      end
   endtask

   task automatic test_reset_in_two;
      ready_in = 1'b0; valid_in = 1'b1;
      ctrl_in = 8'h44; data_in = 138'd4;
      tick();
      ctrl_in = 8'h55; data_in = 138'd5;
      tick();
      rst = 1'b1; flush = 1'b1; ready_in = 1'b1;
      ctrl_in = 8'h66; data_in = 138'd6;
      tick();
      rst = 1'b0; flush = 1'b0; valid_in = 1'b0;
      n_tests++;
      if (valid_out !== 1'b0 || ctrl_out !== 8'h00 || data_out !== 138'd0
          || count_out !== 2'd0 || ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_two got v=%b c=%h d=%0h cnt=%0d rdy=%b exp 0/00/0/0/1",
                  valid_out, ctrl_out, data_out, count_out, ready_out);
      end
      // Nothing stale may surface after reset.
      ready_in = 1'b0; valid_in = 1'b1; ctrl_in = 8'hCC; data_in = 138'hC;
      tick();
      valid_in = 1'b0; ready_in = 1'b1;
      n_tests++;
      if (data_out !== 138'hC || ctrl_out !== 8'hCC || count_out !== 2'd1) begin
         n_fail++;
         $display("FAIL rst_two_after got d=%0h c=%h cnt=%0d exp c/cc/1",
                  data_out, ctrl_out, count_out);
      end
      tick();
      n_tests++;
      if (valid_out !== 1'b0 || count_out !== 2'd0) begin
         n_fail++; $display("FAIL rst_two_drain got v=%b cnt=%0d exp 0/0", valid_out, count_out);
      end
   endtask

   task automatic test_no_skid;
      s_valid_in = 1'b1; s_ready_in = 1'b1;
      s_ctrl_in = 8'h1A; s_data_in = 138'd10;
      #1;
      n_tests++;
      if (s_ready_out !== 1'b1) begin
         n_fail++; $display("FAIL ns_ready_empty got %b exp 1", s_ready_out);
      end
      tick();
      n_tests++;
      if (s_valid_out !== 1'b1 || s_data_out !== 138'd10 || s_count_out !== 2'd1) begin
         n_fail++;
         $display("FAIL ns_first got v=%b d=%0h cnt=%0d exp 1/a/1",
                  s_valid_out, s_data_out, s_count_out);
      end
      s_ctrl_in = 8'h1B; s_data_in = 138'd11;
      tick();
      n_tests++;
      if (s_data_out !== 138'd11 || s_ctrl_out !== 8'h1B) begin
         n_fail++; $display("FAIL ns_second got d=%0h c=%h exp b/1b", s_data_out, s_ctrl_out);
      end
      s_ready_in = 1'b0; s_ctrl_in = 8'h1C; s_data_in = 138'd12;
      #1;
      n_tests++;
      if (s_ready_out !== 1'b0) begin
         n_fail++; $display("FAIL ns_ready_stall got %b exp 0", s_ready_out);
      end
      tick();
      n_tests++;
      if (s_valid_out !== 1'b1 || s_data_out !== 138'd11 || s_ctrl_out !== 8'h1B) begin
         n_fail++;
         $display("FAIL ns_hold got v=%b d=%0h c=%h exp 1/b/1b",
                  s_valid_out, s_data_out, s_ctrl_out);
      end
      s_ready_in = 1'b1;
      #1;
      n_tests++;
      if (s_ready_out !== 1'b1) begin
         n_fail++; $display("FAIL ns_ready_follow got %b exp 1", s_ready_out);
      end
      tick();
      s_valid_in = 1'b0;
      n_tests++;
      if (s_data_out !== 138'd12 || s_ctrl_out !== 8'h1C) begin
         n_fail++; $display("FAIL ns_third got d=%0h c=%h exp c/1c", s_data_out, s_ctrl_out);
      end
      tick();
      n_tests++;
      if (s_valid_out !== 1'b0 || s_ctrl_out !== 8'h00 || s_count_out !== 2'd0
          || s_data_out !== 138'd12) begin
         n_fail++;
         $display("FAIL ns_bubble got v=%b c=%h cnt=%0d d=%0h exp 0/00/0/c",
                  s_valid_out, s_ctrl_out, s_count_out, s_data_out);
      end
   endtask

   initial begin
      test_reset();
      test_single_accept();
      test_backpressure();
      test_streaming();
      test_flush();
      test_reset_in_two();
      test_no_skid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 8, meaning the width of the control field (WB/MEM/EX bits); legal range 1..64.
REQ-002 The block SHALL have parameter DATA_W, default 138, meaning the width of the data field (addresses, operands, immediates, register numbers); legal range 1..512.
REQ-003 The block SHALL have parameter SKID, default 1, meaning the mode: 1 gives a two-entry skid buffer, 0 gives a single register.
REQ-004 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit, reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port flush_i, input, 1 bit, a synchronous discard of all held entries.
REQ-007 The block SHALL have port valid_i, input, 1 bit, meaning the upstream entry is valid.
REQ-008 The block SHALL have port ready_o, output, 1 bit, meaning the stage can accept an entry this cycle.
REQ-009 The block SHALL have port ctrl_i, input, CTRL_W bits, the upstream control field.
REQ-010 The block SHALL have port data_i, input, DATA_W bits, the upstream data field.
REQ-011 The block SHALL have port valid_o, output, 1 bit, meaning the downstream entry is valid.
REQ-012 The block SHALL have port ready_i, input, 1 bit, meaning downstream accepts this cycle.
REQ-013 The block SHALL have port ctrl_o, output, CTRL_W bits, the registered control field.
REQ-014 The block SHALL have port data_o, output, DATA_W bits, the registered data field.
REQ-015 The block SHALL have port count_o, output, 2 bits, the occupancy (0..2; 0..1 when SKID=0).

Function
REQ-016 The block SHALL define accept = valid_i & ready_o and issue = valid_o & ready_i, both evaluated in the same cycle.
REQ-017 When SKID=1, the block SHALL hold state EMPTY, ONE or TWO, with entries main (drives outputs) and skid.
REQ-018 When SKID=1, ready_o SHALL equal (state != TWO); it SHALL be derived from registered state only, with no combinational path from ready_i.
REQ-019 When SKID=1, transitions SHALL be:
  - EMPTY + accept -> ONE, main loaded.
  - ONE + accept + issue -> ONE, main loaded.
  - ONE + accept + !issue -> TWO, skid loaded.
  - ONE + !accept + issue -> EMPTY.
  - TWO + issue -> ONE, skid moved to main.
  - All other cases -> state held.
REQ-020 When SKID=0, ready_o SHALL equal !valid_o | ready_i; a single register SHALL load on accept; valid_o SHALL clear on issue without accept.
REQ-021 Latency SHALL be exactly one cycle from accept into an empty stage to valid_o=1 with that entry on ctrl_o/data_o.
REQ-022 Entries SHALL leave in acceptance order, with no loss or duplication.
REQ-023 While valid_o=1 and ready_i=0, ctrl_o, data_o and valid_o SHALL remain unchanged.
REQ-024 Whenever valid_o=0, ctrl_o SHALL be all zeros (bubble: no RegWrite/MemWrite asserted); data_o SHALL hold its last value.
REQ-025 flush_i=1 SHALL, at the next edge, set the state to EMPTY, valid_o=0, ctrl_o=0 and count_o=0.
REQ-026 An entry offered in a flush cycle SHALL be discarded, and issue in that cycle still counts as consumed downstream.
REQ-027 rst_i SHALL take priority over flush_i, and flush_i SHALL take priority over accept/issue.
REQ-028 count_o SHALL equal the number of held entries after each edge.

Reset
REQ-029 With rst_i=1 at a rising edge, the block SHALL set state=EMPTY, valid_o=0, ctrl_o=0, data_o=0, count_o=0, and clear skid contents to 0.
REQ-030 With rst_i=1, inputs in that cycle SHALL be ignored; ready_o SHALL read 1 from the first edge after reset is asserted.
REQ-031 Reset asserted mid-operation, including in state TWO, SHALL discard all entries, with no partial update.

Verification
REQ-032 Reset then single accept: ctrl_i=8'hA5, data_i=1, ready_i=1 -> one cycle later valid_o=1, ctrl_o=A5, data_o=1; the following cycle valid_o=0, ctrl_o=0.
REQ-033 Back-pressure fill: ready_i=0, three consecutive valid_i with data 1,2,3 -> 1 and 2 held, ready_o=0 after the 2nd accept, count_o=2, 3 not accepted; ready_i=1 -> data_o sequence 1,2, then 3 after re-offer.
REQ-034 Streaming: valid_i=1, ready_i=1 for 16 cycles with data 0..15 -> data_o sequence 0..15, count_o stays 1, ready_o stays 1.
REQ-035 Flush in TWO with valid_i=1 data 9 -> next cycle valid_o=0, ctrl_o=0, count_o=0, and 9 never appears.
REQ-036 SKID=0 build: ready_i toggled 1,0,1 under continuous input -> ready_o follows !valid_o | ready_i combinationally, order preserved.
REQ-037 rst_i in state TWO concurrent with flush_i and valid_i -> all outputs zero next cycle, ready_o=1.
